// File: rtl/banked_register_file_pkg.sv
// Shared types and helpers for the banked register file: clear FSM encoding,
// address-width derivation and the hardwired-zero index.
package banked_rf_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } clr_state_t;

   localparam int ZERO_IDX = 0;

   // A single-entry file still needs one address bit to keep port widths legal.
   function automatic int calc_aw(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/banked_register_file_bank.sv
// One register bank: NUM_REGS x WIDTH storage, one write port, two
// combinational read ports. The owner decides which bank sees the write.
module rf_bank
   import banked_rf_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int NUM_REGS = 8,
   localparam int AW      = calc_aw(NUM_REGS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr_a,
   input  logic [AW-1:0]    raddr_b,
   output logic [WIDTH-1:0] rdata_a,
   output logic [WIDTH-1:0] rdata_b
);

   logic [NUM_REGS-1:0][WIDTH-1:0] regs;

   always_ff @(posedge clk) begin
      if (rst) begin
         regs <= '0;
      end else if (we) begin
         regs[waddr] <= wdata;
      end
   end

   assign rdata_a = regs[raddr_a];
   assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/banked_register_file.sv
// Two-bank register file with 1-cycle registered reads, write-to-read bypass,
// optional hardwired zero register and a serial clear of the active bank.
module banked_register_file
   import banked_rf_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int NUM_REGS = 8,
   parameter int ZERO_REG = 1,
   localparam int AW      = calc_aw(NUM_REGS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [AW-1:0]    rd_addr_a,
   input  logic [AW-1:0]    rd_addr_b,
   output logic [WIDTH-1:0] rd_data_a,
   output logic [WIDTH-1:0] rd_data_b,
   input  logic             bank_swap,
   output logic             bank_active,
   input  logic             clear_req,
   output logic             clear_busy
);

   localparam int NUM_PORTS = 2;

   clr_state_t  state;
   logic [AW-1:0] idx;
   logic          active;

   logic is_idle;
   logic zero_wr;
   logic wr_acc;
   logic clr_wr;

   logic [1:0]                      bank_we;
   logic [AW-1:0]                   bank_waddr;
   logic [WIDTH-1:0]                bank_wdata;
   logic [1:0][WIDTH-1:0]           bank_rd_a;
   logic [1:0][WIDTH-1:0]           bank_rd_b;

   logic [NUM_PORTS-1:0][AW-1:0]    rd_addr;
   logic [NUM_PORTS-1:0][WIDTH-1:0] rd_raw;
   logic [NUM_PORTS-1:0][WIDTH-1:0] rd_next;
   logic [NUM_PORTS-1:0][WIDTH-1:0] rd_q;

   assign is_idle = (state == IDLE);
   assign clr_wr  = (state == CLEAR);
   assign zero_wr = (ZERO_REG != 0) && (wr_addr == AW'(ZERO_IDX));
   assign wr_acc  = wr_en && is_idle && !zero_wr;

   // The sequencer and the write port share the bank write port; they never
   // collide because writes are only accepted in IDLE.
   always_comb begin
      bank_we         = '0;
      bank_we[active] = wr_acc || clr_wr;
      bank_waddr      = clr_wr ? idx : wr_addr;
      bank_wdata      = clr_wr ? '0 : wr_data;
   end

   for (genvar g = 0; g < 2; g++) begin : g_bank
      rf_bank #(
         .WIDTH    (WIDTH),
         .NUM_REGS (NUM_REGS)
      ) u_bank (
         .clk     (clk),
         .rst     (rst),
         .we      (bank_we[g]),
         .waddr   (bank_waddr),
         .wdata   (bank_wdata),
         .raddr_a (rd_addr_a),
         .raddr_b (rd_addr_b),
         .rdata_a (bank_rd_a[g]),
         .rdata_b (bank_rd_b[g])
      );
   end

   assign rd_addr[0] = rd_addr_a;
   assign rd_addr[1] = rd_addr_b;
   assign rd_raw[0]  = bank_rd_a[active];
   assign rd_raw[1]  = bank_rd_b[active];

   // Bypass only forwards accepted port writes; clear writes are not forwarded.
   always_comb begin
      rd_next = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         rd_next[p] = rd_raw[p];
         if (wr_acc && (wr_addr == rd_addr[p]))
            rd_next[p] = wr_data;
         if ((ZERO_REG != 0) && (rd_addr[p] == AW'(ZERO_IDX)))
            rd_next[p] = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         idx    <= '0;
         active <= 1'b0;
         rd_q   <= '0;
      end else begin
         rd_q <= rd_next;
         case (state)
            IDLE: begin
               if (bank_swap)
                  active <= ~active;
               if (clear_req) begin
                  state <= CLEAR;
                  idx   <= '0;
               end
            end
            CLEAR: begin
               idx <= idx + 1'b1;
               if (idx == AW'(NUM_REGS - 1))
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign rd_data_a   = rd_q[0];
   assign rd_data_b   = rd_q[1];
   assign bank_active = active;
   assign clear_busy  = clr_wr;

endmodule

// File: tb/tb_banked_register_file.sv
// Directed bench for banked_register_file: stimulus pushes expected outputs
// into a queue, a negedge monitor pops one entry per clock and compares.
module tb_banked_register_file;

   localparam int WIDTH    = 8;
   localparam int NUM_REGS = 8;
   localparam int AW       = 3;

   logic             clk = 1'b0;
   logic             rst;
   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic [WIDTH-1:0] wr_data;
   logic [AW-1:0]    rd_addr_a;
   logic [AW-1:0]    rd_addr_b;
   logic [WIDTH-1:0] rd_data_a;
   logic [WIDTH-1:0] rd_data_b;
   logic             bank_swap;
   logic             bank_active;
   logic             clear_req;
   logic             clear_busy;

   banked_register_file #(
      .WIDTH    (WIDTH),
      .NUM_REGS (NUM_REGS),
      .ZERO_REG (1)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .rd_addr_a   (rd_addr_a),
      .rd_addr_b   (rd_addr_b),
      .rd_data_a   (rd_data_a),
      .rd_data_b   (rd_data_b),
      .bank_swap   (bank_swap),
      .bank_active (bank_active),
      .clear_req   (clear_req),
      .clear_busy  (clear_busy)
   );

   always #5 clk = ~clk;

   // -1 in a field means "do not check"
   typedef struct {
      string name;
      int    a;
      int    b;
      int    ba;
      int    busy;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic cmp(input string name, input string sig, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s %s got=%0h expected=%0h", name, sig, got, want);
      end
   endtask

   initial begin
      exp_t e;
      @(posedge clk);
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.a >= 0)    cmp(e.name, "rd_data_a",   int'(rd_data_a),   e.a);
            if (e.b >= 0)    cmp(e.name, "rd_data_b",   int'(rd_data_b),   e.b);
            if (e.ba >= 0)   cmp(e.name, "bank_active", int'(bank_active), e.ba);
            if (e.busy >= 0) cmp(e.name, "clear_busy",  int'(clear_busy),  e.busy);
         end
      end
   end

   // One clock of stimulus: queue what the outputs must show after this edge.
   task automatic step(input string name, input int a, input int b, input int ba, input int busy);
      exp_t e;
      e.name = name; e.a = a; e.b = b; e.ba = ba; e.busy = busy;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      rst       = 1'b0;
      wr_en     = 1'b0;
      bank_swap = 1'b0;
      clear_req = 1'b0;
   endtask

   task automatic wr(input int addr, input int data);
      logic [31:0] av, dv;
      av = 32'(addr);
      dv = 32'(data);
      wr_en   = 1'b1;
      wr_addr = av[AW-1:0];
      wr_data = dv[WIDTH-1:0];
   endtask

   task automatic rd(input int a, input int b);
      logic [31:0] av, bv;
      av = 32'(a);
      bv = 32'(b);
      rd_addr_a = av[AW-1:0];
      rd_addr_b = bv[AW-1:0];
   endtask

   initial begin
      rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      rd_addr_a = '0; rd_addr_b = '0; bank_swap = 1'b0; clear_req = 1'b0;

      step("reset", 0, 0, 0, 0);
      rst = 1'b1;
      step("reset2", 0, 0, 0, 0);

      // basic write, 1-cycle read latency
      wr(3, 'hA5); rd(0, 5);        step("wr_r3", 0, 0, 0, 0);
      rd(3, 5);                     step("rd_r3", 'hA5, 0, 0, 0);
      wr(4, 'h3C); rd(4, 4);        step("bypass_r4", 'h3C, 'h3C, 0, 0);
      wr(0, 'hFF); rd(0, 0);        step("zero_bypass", 0, 0, 0, 0);
      rd(0, 4);                     step("zero_read", 0, 'h3C, 0, 0);

      // bank swap: swap cycle reads the old bank, shadow keeps its data
      wr(2, 'h11); rd(2, 3);        step("b0_wr_r2", 'h11, 'hA5, 0, 0);
      bank_swap = 1'b1;             step("swap_to_b1", 'h11, 'hA5, 1, 0);
      wr(2, 'h22);                  step("b1_wr_r2", 'h22, 0, 1, 0);
      bank_swap = 1'b1;             step("swap_to_b0", 'h22, 0, 0, 0);
      step("b0_r2_kept", 'h11, 'hA5, 0, 0);

      // fill bank 0 then clear it; strobes mid-clear must be dropped
      for (int i = 1; i < NUM_REGS; i++) begin
         wr(i, 'h80 + i); rd(0, 0);
         step("fill", 0, 0, 0, 0);
      end
      rd(5, 7); clear_req = 1'b1;   step("clr_start", 'h85, 'h87, 0, 1);
      for (int k = 1; k <= NUM_REGS; k++) begin
         rd(1, 7);
         if (k == 4) begin
            wr(6, 'h77); bank_swap = 1'b1; clear_req = 1'b1;
         end
         step("clr_run", (k <= 2) ? 'h81 : 0, 'h87, 0, (k < NUM_REGS) ? 1 : 0);
      end
      for (int i = 0; i < 4; i++) begin
         rd(i, i + 4);
         step("post_clr", 0, 0, 0, 0);
      end
      bank_swap = 1'b1; rd(2, 6);   step("swap_b1", 0, 0, 1, 0);
      step("shadow_r2", 'h22, 0, 1, 0);

      // swap + clear together: only the new bank is cleared
      wr(5, 'h55); rd(5, 2);        step("b1_wr_r5", 'h55, 'h22, 1, 0);
      bank_swap = 1'b1;             step("swap_b0", 'h55, 'h22, 0, 0);
      wr(1, 'hA1); rd(1, 6);        step("b0_wr_r1", 'hA1, 0, 0, 0);
      wr(6, 'hA6);                  step("b0_wr_r6", 'hA1, 'hA6, 0, 0);
      bank_swap = 1'b1; clear_req = 1'b1; rd(2, 5);
      step("swap_clr", 0, 0, 1, 1);
      for (int k = 1; k <= NUM_REGS; k++) begin
         rd(2, 5);
         step("swap_clr_run", (k <= 3) ? 'h22 : 0, (k <= 6) ? 'h55 : 0, 1,
              (k < NUM_REGS) ? 1 : 0);
      end
      rd(2, 5);                     step("b1_cleared", 0, 0, 1, 0);
      bank_swap = 1'b1; rd(1, 6);   step("swap_back", 0, 0, 0, 0);
      step("b0_kept", 'hA1, 'hA6, 0, 0);

      // reset in the third clear cycle aborts and wipes everything
      wr(7, 'hE7); rd(7, 1);        step("wr_r7", 'hE7, 'hA1, 0, 0);
      clear_req = 1'b1;             step("clr3_start", 'hE7, 'hA1, 0, 1);
      step("clr3_c1", 'hE7, 'hA1, 0, 1);
      step("clr3_c2", 'hE7, 'hA1, 0, 1);
      rst = 1'b1;                   step("rst_mid_clr", 0, 0, 0, 0);
      rd(7, 6);                     step("rst_r7", 0, 0, 0, 0);
      rd(1, 2);                     step("rst_r1", 0, 0, 0, 0);

      // reset with bank 1 active
      wr(4, 'h44); rd(4, 0);        step("b0_r4", 'h44, 0, 0, 0);
      bank_swap = 1'b1;             step("swap_b1b", 'h44, 0, 1, 0);
      wr(4, 'h4B);                  step("b1_r4", 'h4B, 0, 1, 0);
      rst = 1'b1;                   step("rst_b1", 0, 0, 0, 0);
      step("rst_b0_r4", 0, 0, 0, 0);
      bank_swap = 1'b1;             step("rst_swap", 0, 0, 1, 0);
      step("rst_b1_r4", 0, 0, 1, 0);

      // write and clear_req together: the written register is cleared too
      wr(3, 'h33); clear_req = 1'b1; rd(3, 3);
      step("wr_clr", 'h33, 'h33, 1, 1);
      for (int k = 1; k <= NUM_REGS; k++) begin
         rd(3, 3);
         step("wr_clr_run", (k <= 4) ? 'h33 : 0, (k <= 4) ? 'h33 : 0, 1,
              (k < NUM_REGS) ? 1 : 0);
      end
      rd(3, 3);                     step("wr_clr_done", 0, 0, 1, 0);

      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain left=%0d expected=0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
